// File: rtl/ppi_strobed_ports_if.sv
// CPU-side register bus of the strobed parallel port block.
interface ppi_strobed_ports_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 2
) ();
    logic [ADDR_W-1:0] addr;
    logic              rd;
    logic              wr;
    logic [WIDTH-1:0]  data_in;
    logic [WIDTH-1:0]  data_out;
    logic              data_oe;

    modport master (
        output addr, rd, wr, data_in,
        input  data_out, data_oe
    );

    modport slave (
        input  addr, rd, wr, data_in,
        output data_out, data_oe
    );
endinterface

// File: rtl/ppi_strobed_ports.sv
// NUM_PORTS parallel ports, each run-time configurable as simple or strobed
// (STB/IBF, OBF/ACK, INTR) input or output, behind a small register bus.
module ppi_strobed_ports #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ADDR_W    = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    ppi_strobed_ports_if.slave         bus,
    input  logic [NUM_PORTS*WIDTH-1:0] port_in,
    output logic [NUM_PORTS*WIDTH-1:0] port_out,
    output logic [NUM_PORTS-1:0]       port_oe,
    input  logic [NUM_PORTS-1:0]       stb_n,
    input  logic [NUM_PORTS-1:0]       ack_n,
    output logic [NUM_PORTS-1:0]       ibf,
    output logic [NUM_PORTS-1:0]       obf_n,
    output logic [NUM_PORTS-1:0]       intr,
    output logic                       irq
);

    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned PW    = NUM_PORTS * WIDTH;
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(NUM_PORTS);
    localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(NUM_PORTS + 1);

    // per-port configuration and handshake state; port_oe doubles as ~dir
    logic [NUM_PORTS-1:0] ie_q, mode_q, ovr_q;
    logic [PW-1:0]        latch_q;
    logic [NUM_PORTS-1:0] stb_s1, stb_s2, stb_prev;
    logic [NUM_PORTS-1:0] ack_s1, ack_s2, ack_prev;

    logic [NUM_PORTS-1:0] ie_nx, mode_nx, ovr_nx, oe_nx;
    logic [PW-1:0]        latch_nx, port_out_nx;
    logic [NUM_PORTS-1:0] ibf_nx, obf_n_nx, intr_nx;
    logic [NUM_PORTS-1:0] stb_s1_nx, stb_s2_nx, stb_prev_nx;
    logic [NUM_PORTS-1:0] ack_s1_nx, ack_s2_nx, ack_prev_nx;
    logic [WIDTH-1:0]     data_out_nx;
    logic                 data_oe_nx;
    logic                 irq_nx;

    logic [NUM_PORTS-1:0] stb_fall, stb_rise, ack_fall, ack_rise;
    logic [WIDTH-1:0]     status;
    logic                 rd_en, ctl_hit, sel, rd_p, wr_p;
    logic [IDX_W-1:0]     ctl_idx;

    // next-state: bus decode, synchronizer shift, per-port handshake rules
    always_comb begin
        ie_nx       = ie_q;
        mode_nx     = mode_q;
        oe_nx       = port_oe;
        ovr_nx      = ovr_q;
        latch_nx    = latch_q;
        port_out_nx = port_out;
        ibf_nx      = ibf;
        obf_n_nx    = obf_n;
        intr_nx     = intr;
        stb_s1_nx   = stb_n;
        stb_s2_nx   = stb_s1;
        stb_prev_nx = stb_s2;
        ack_s1_nx   = ack_n;
        ack_s2_nx   = ack_s1;
        ack_prev_nx = ack_s2;
        stb_fall    = stb_prev & ~stb_s2;
        stb_rise    = ~stb_prev & stb_s2;
        ack_fall    = ack_prev & ~ack_s2;
        ack_rise    = ~ack_prev & ack_s2;
        rd_en       = bus.rd & ~bus.wr;
        ctl_hit     = bus.wr && (bus.addr == CTRL_ADDR);
        ctl_idx     = bus.data_in[IDX_W-1:0];
        data_oe_nx  = rd_en;
        data_out_nx = bus.data_out;
        sel         = 1'b0;
        rd_p        = 1'b0;
        wr_p        = 1'b0;

        status = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            status[3*p]     = port_oe[p] ? ~obf_n[p] : ibf[p];
            status[3*p + 1] = intr[p];
            status[3*p + 2] = ovr_q[p];
        end

        // status/control reads; control and unmapped addresses read as zero
        if (rd_en) begin
            data_out_nx = '0;
            if (bus.addr == STATUS_ADDR) begin
                data_out_nx = status;
                ovr_nx      = '0;
            end
        end

        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            sel  = (bus.addr == ADDR_W'(p));
            rd_p = rd_en && sel;
            wr_p = bus.wr && sel;

            if (rd_p) begin
                if (port_oe[p])
                    data_out_nx = port_out[p*WIDTH +: WIDTH];
                else if (mode_q[p])
                    data_out_nx = latch_q[p*WIDTH +: WIDTH];
                else
                    data_out_nx = port_in[p*WIDTH +: WIDTH];
            end

            if (!port_oe[p]) begin
                if (mode_q[p]) begin
                    if (rd_p) begin
                        ibf_nx[p]  = 1'b0;
                        intr_nx[p] = 1'b0;
                    end
                    // a read in the same cycle frees the buffer, so the strobe captures
                    if (stb_fall[p]) begin
                        if (!ibf[p] || rd_p) begin
                            latch_nx[p*WIDTH +: WIDTH] = port_in[p*WIDTH +: WIDTH];
                            ibf_nx[p] = 1'b1;
                        end else begin
                            ovr_nx[p] = 1'b1;
                        end
                    end
                    if (stb_rise[p] && ibf[p] && ie_q[p])
                        intr_nx[p] = 1'b1;
                end
            end else begin
                if (wr_p) begin
                    port_out_nx[p*WIDTH +: WIDTH] = bus.data_in;
                    if (mode_q[p]) begin
                        obf_n_nx[p] = 1'b0;
                        intr_nx[p]  = 1'b0;
                    end
                end
                if (mode_q[p]) begin
                    if (ack_fall[p] && !wr_p)
                        obf_n_nx[p] = 1'b1;
                    if (ack_rise[p] && ie_q[p])
                        intr_nx[p] = 1'b1;
                end
            end

            // control write reconfigures the port and overrides any event
            if (ctl_hit && (IDX_W'(p) == ctl_idx)) begin
                ie_nx[p]   = bus.data_in[WIDTH-1];
                mode_nx[p] = bus.data_in[WIDTH-2];
                oe_nx[p]   = ~bus.data_in[WIDTH-3];
                port_out_nx[p*WIDTH +: WIDTH] = '0;
                latch_nx[p*WIDTH +: WIDTH]    = '0;
                ibf_nx[p]   = 1'b0;
                intr_nx[p]  = 1'b0;
                ovr_nx[p]   = 1'b0;
                obf_n_nx[p] = 1'b1;
            end
        end

        irq_nx = |intr_nx;
    end

    // state register; synchronizers preset high so reset never fakes an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            ie_q         <= '0;
            mode_q       <= '0;
            port_oe      <= '0;
            ovr_q        <= '0;
            latch_q      <= '0;
            port_out     <= '0;
            ibf          <= '0;
            obf_n        <= '1;
            intr         <= '0;
            irq          <= 1'b0;
            stb_s1       <= '1;
            stb_s2       <= '1;
            stb_prev     <= '1;
            ack_s1       <= '1;
            ack_s2       <= '1;
            ack_prev     <= '1;
            bus.data_out <= '0;
            bus.data_oe  <= 1'b0;
        end else begin
            ie_q         <= ie_nx;
            mode_q       <= mode_nx;
            port_oe      <= oe_nx;
            ovr_q        <= ovr_nx;
            latch_q      <= latch_nx;
            port_out     <= port_out_nx;
            ibf          <= ibf_nx;
            obf_n        <= obf_n_nx;
            intr         <= intr_nx;
            irq          <= irq_nx;
            stb_s1       <= stb_s1_nx;
            stb_s2       <= stb_s2_nx;
            stb_prev     <= stb_prev_nx;
            ack_s1       <= ack_s1_nx;
            ack_s2       <= ack_s2_nx;
            ack_prev     <= ack_prev_nx;
            bus.data_out <= data_out_nx;
            bus.data_oe  <= data_oe_nx;
        end
    end

endmodule

// File: tb/tb_ppi_strobed_ports.sv
// Directed bench for ppi_strobed_ports (WIDTH=8, NUM_PORTS=2, ADDR_W=2).
module tb_ppi_strobed_ports;
    localparam int unsigned WIDTH     = 8;
    localparam int unsigned NUM_PORTS = 2;
    localparam int unsigned ADDR_W    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] port_in, port_out;
    logic [1:0]  port_oe, stb_n, ack_n, ibf, obf_n, intr;
    logic        irq;
    logic [7:0]  rdata;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    ppi_strobed_ports_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    ppi_strobed_ports #(.WIDTH(WIDTH), .NUM_PORTS(NUM_PORTS), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .port_in  (port_in),
        .port_out (port_out),
        .port_oe  (port_oe),
        .stb_n    (stb_n),
        .ack_n    (ack_n),
        .ibf      (ibf),
        .obf_n    (obf_n),
        .intr     (intr),
        .irq      (irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        bus.addr    = a;
        bus.data_in = d;
        bus.wr      = 1'b1;
        tick();
        bus.wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
        bus.addr = a;
        bus.rd   = 1'b1;
        tick();
        bus.rd = 1'b0;
        chk("rd_data_oe", 32'(bus.data_oe), 32'd1);
        d = bus.data_out;
    endtask

    initial begin
        reset       = 1'b1;
        bus.addr    = '0;
        bus.rd      = 1'b0;
        bus.wr      = 1'b0;
        bus.data_in = '0;
        port_in     = '0;
        stb_n       = 2'b11;
        ack_n       = 2'b11;
        ticks(3);
        reset = 1'b0;
        tick();

        // reset state
        chk("rst_port_out", 32'(port_out), 32'h0);
        chk("rst_port_oe",  32'(port_oe),  32'h0);
        chk("rst_ibf",      32'(ibf),      32'h0);
        chk("rst_obf_n",    32'(obf_n),    32'h3);
        chk("rst_intr",     32'(intr),     32'h0);
        chk("rst_irq",      32'(irq),      32'h0);
        chk("rst_data_oe",  32'(bus.data_oe),  32'h0);
        chk("rst_data_out", 32'(bus.data_out), 32'h0);

        // mode 0: port 0 output, port 1 input
        bus_wr(2'd3, 8'h00);
        chk("m0_port_oe", 32'(port_oe), 32'h1);
        bus_wr(2'd0, 8'hA5);
        chk("m0_port_out", 32'(port_out), 32'h00A5);
        bus_rd(2'd0, rdata);
        chk("m0_rd_out", 32'(rdata), 32'hA5);
        port_in = 16'h3C00;
        bus_rd(2'd1, rdata);
        chk("m0_rd_in", 32'(rdata), 32'h3C);
        tick();
        chk("m0_oe_drop", 32'(bus.data_oe), 32'h0);
        chk("m0_out_hold", 32'(bus.data_out), 32'h3C);
        bus_wr(2'd1, 8'h11);
        chk("m0_in_wr_ignored", 32'(port_out), 32'h00A5);
        bus_rd(2'd3, rdata);
        chk("ctrl_rd_zero", 32'(rdata), 32'h0);

        // mode 1 input on port 1
        bus_wr(2'd3, 8'hE1);
        chk("m1i_port_oe", 32'(port_oe), 32'h1);
        port_in[15:8] = 8'h5A;
        stb_n[1] = 1'b0;
        ticks(2);
        chk("m1i_ibf_early", 32'(ibf), 32'h0);
        tick();
        chk("m1i_ibf_set", 32'(ibf), 32'h2);
        stb_n[1] = 1'b1;
        ticks(2);
        chk("m1i_intr_early", 32'(intr), 32'h0);
        tick();
        chk("m1i_intr_set", 32'(intr), 32'h2);
        chk("m1i_irq_set", 32'(irq), 32'h1);
        bus_rd(2'd2, rdata);
        chk("m1i_status", 32'(rdata), 32'h18);

        // overrun: second strobe while the buffer is still full
        port_in[15:8] = 8'hFF;
        stb_n[1] = 1'b0;
        ticks(3);
        stb_n[1] = 1'b1;
        ticks(3);
        bus_rd(2'd2, rdata);
        chk("ovr_status", 32'(rdata), 32'h38);
        bus_rd(2'd2, rdata);
        chk("ovr_cleared", 32'(rdata), 32'h18);
        bus_rd(2'd1, rdata);
        chk("ovr_latch_kept", 32'(rdata), 32'h5A);
        chk("m1i_ibf_clr", 32'(ibf), 32'h0);
        chk("m1i_intr_clr", 32'(intr), 32'h0);
        chk("m1i_irq_clr", 32'(irq), 32'h0);

        // mode 1 output on port 0
        bus_wr(2'd3, 8'hC0);
        chk("m1o_ctl_clear", 32'(port_out), 32'h0000);
        chk("m1o_obf_idle", 32'(obf_n), 32'h3);
        bus_wr(2'd0, 8'h81);
        chk("m1o_port_out", 32'(port_out), 32'h0081);
        chk("m1o_obf_set", 32'(obf_n), 32'h2);
        bus_rd(2'd2, rdata);
        chk("m1o_status", 32'(rdata), 32'h01);
        ack_n[0] = 1'b0;
        ticks(2);
        chk("m1o_obf_early", 32'(obf_n), 32'h2);
        tick();
        chk("m1o_obf_ack", 32'(obf_n), 32'h3);
        ack_n[0] = 1'b1;
        ticks(3);
        chk("m1o_intr_set", 32'(intr), 32'h1);
        chk("m1o_irq_set", 32'(irq), 32'h1);
        bus_wr(2'd0, 8'h42);
        chk("m1o_intr_clr", 32'(intr), 32'h0);
        chk("m1o_obf_again", 32'(obf_n), 32'h2);

        // collision: rd and wr together, the write wins and no read data
        bus.addr    = 2'd0;
        bus.data_in = 8'h99;
        bus.rd      = 1'b1;
        bus.wr      = 1'b1;
        tick();
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        chk("col_rdwr_oe", 32'(bus.data_oe), 32'h0);
        chk("col_rdwr_wr", 32'(port_out), 32'h0099);

        // collision: data read on the same edge as a capture
        port_in[15:8] = 8'h77;
        stb_n[1] = 1'b0;
        ticks(2);
        bus.addr = 2'd1;
        bus.rd   = 1'b1;
        tick();
        bus.rd = 1'b0;
        chk("col_cap_oe",  32'(bus.data_oe),  32'h1);
        chk("col_cap_old", 32'(bus.data_out), 32'h5A);
        chk("col_cap_ibf", 32'(ibf), 32'h2);
        stb_n[1] = 1'b1;
        ticks(3);
        bus_rd(2'd1, rdata);
        chk("col_cap_new", 32'(rdata), 32'h77);

        // reset in the middle of a handshake
        stb_n[1] = 1'b0;
        ticks(3);
        stb_n[1] = 1'b1;
        ticks(3);
        chk("mid_intr", 32'(intr), 32'h2);
        stb_n[1] = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_ibf",      32'(ibf),      32'h0);
        chk("mid_rst_intr",     32'(intr),     32'h0);
        chk("mid_rst_irq",      32'(irq),      32'h0);
        chk("mid_rst_obf_n",    32'(obf_n),    32'h3);
        chk("mid_rst_port_out", 32'(port_out), 32'h0);
        chk("mid_rst_port_oe",  32'(port_oe),  32'h0);
        chk("mid_rst_data_out", 32'(bus.data_out), 32'h0);
        ticks(3);
        stb_n[1] = 1'b1;
        ticks(4);
        chk("mid_no_ibf",  32'(ibf),  32'h0);
        chk("mid_no_intr", 32'(intr), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ppi_strobed_ports.md
# ppi_strobed_ports

Clocked, parametrised successor to the PPI mode-0 port block: NUM_PORTS ports of WIDTH bits, each independently configurable at run time as simple (mode 0) or strobed-handshake (mode 1), input or output. It sits between the CPU-side register bus and the external port pins. It adds per-port STB/IBF, OBF/ACK and INTR handshaking, overrun detection and a combined interrupt request.

## Interface
- WIDTH, 8, port and data bus width.
- NUM_PORTS, 2, number of ports; 3*NUM_PORTS <= WIDTH and NUM_PORTS+2 <= 2**ADDR_W.
- ADDR_W, 2, register address width.

- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- addr  in  ADDR_W  0..NUM_PORTS-1 = port data; NUM_PORTS = status (read-only); NUM_PORTS+1 = control (write-only).
- rd  in  1  one-cycle read strobe.
- wr  in  1  one-cycle write strobe.
- data_in  in  WIDTH  CPU write data.
- data_out  out  WIDTH  registered read data.
- data_oe  out  1  high for one cycle with valid data_out.
- port_in  in  NUM_PORTS*WIDTH  pin inputs, port p at [p*WIDTH +: WIDTH].
- port_out  out  NUM_PORTS*WIDTH  output latches.
- port_oe  out  NUM_PORTS  port drives its pins.
- stb_n  in  NUM_PORTS  input strobe, active-low, asynchronous.
- ack_n  in  NUM_PORTS  output acknowledge, active-low, asynchronous.
- ibf  out  NUM_PORTS  input buffer full.
- obf_n  out  NUM_PORTS  output buffer full, active-low.
- intr  out  NUM_PORTS  per-port interrupt.
- irq  out  1  OR of intr.

## Operation
- Reset: all ports input, mode 0, ie=0. port_out=0, port_oe=0, input latches=0, ibf=0, obf_n=1, intr=0, overrun=0, data_out=0, data_oe=0. Synchronizers preset to 1, so no false edge after reset; reset mid-handshake abandons it.
- Control write, data_in fields:
  - [WIDTH-1] ie.
  - [WIDTH-2] mode: 1 = strobed.
  - [WIDTH-3] dir: 1 = input.
  - low clog2(NUM_PORTS) bits: port index. An index >= NUM_PORTS is ignored.
  - Effect on that port: port_out, input latch, ibf, intr, overrun cleared; obf_n=1.
- port_oe[p] = (dir==output), in both modes.
- Mode 0 input: a read returns live port_in. Writes are ignored.
- Mode 0 output: a write loads port_out. A read returns port_out.
- Mode 1 input:
  - Synchronized stb_n falling edge with ibf=0: capture port_in into the latch; set ibf.
  - Falling edge with ibf=1: latch unchanged; set overrun.
  - Rising edge with ibf=1 and ie=1: set intr.
  - Data read: returns the latch; clears ibf and intr.
- Mode 1 output:
  - Data write: loads port_out; obf_n=0; clears intr. A write while obf_n=0 overwrites; obf_n stays 0.
  - Synchronized ack_n falling edge: obf_n=1.
  - ack_n rising edge with ie=1: set intr.
  - A read returns port_out.
- Status read: bit 3p = ibf[p] (input) or ~obf_n[p] (output); bit 3p+1 = intr[p]; bit 3p+2 = overrun[p]. Other bits are 0. A status read clears all overrun flags.
- Reading control returns 0. Writing status has no effect.

## Timing
- Read latency 1: rd at edge n gives data_out/data_oe valid after edge n+1 for one cycle. Otherwise data_oe=0 and data_out holds its last value.
- rd and wr in the same cycle: the write executes, the read is dropped (data_oe=0).
- Writes take effect after the strobe edge: port_out, obf_n, intr update the next cycle.
- stb_n/ack_n path: 2-flop synchronizer plus edge register. A level first sampled low at edge 0 is acted on at edge 2, so ibf/obf_n change after edge 2.
- port_in is captured at edge 2; the source holds it stable from before edge 0 through edge 2.
- Minimum stb_n/ack_n low and high widths: 3 clocks.
- Same-cycle collisions:
  - Data read and capture on one port: capture wins; ibf=1, intr per rule; the read returns the previous latch value.
  - Data write and ack falling edge: write wins; obf_n=0.
  - Control write and handshake event on the same port: control clear wins.

## Test plan
- Reset: assert reset mid-handshake (ibf=1, intr=1) -> next cycle all outputs at reset values; no ibf rises when stb_n is released afterwards.
- Mode 0: control 8'h00 (port 0 output), write 8'hA5 to addr 0 -> port_out[7:0]=A5, port_oe[0]=1; port 1 input with port_in=8'h3C, read addr 1 -> data_out=3C, data_oe=1 one cycle after rd.
- Mode 1 input: control 8'hE1, port_in=8'h5A, stb_n low 3 cycles -> ibf[1] after edge 2, intr[1]/irq after release; read addr 1 -> 5A, then ibf=0, intr=0.
- Overrun: second strobe with port_in=8'hFF before the read -> latch keeps 5A; status bit 5=1; status read clears it.
- Mode 1 output: control 8'hC0, write 8'h81 -> obf_n[0]=0; ack_n pulse -> obf_n=1 after edge 2, intr[0]=1 on release; next write clears intr.
- Collisions: rd+wr same cycle -> data_oe=0; data read coinciding with capture of 8'h77 -> returns old byte, ibf stays 1, next read returns 77.
